// File: rtl/spi_slave_frame.sv
// SPI slave (sclk idle low): samples mosi on sclk fall and drives miso from rise, one FRAME_BITS frame per cs-low window.
// All pins are resynchronised into clk; a frame commits to rx_data only when exactly FRAME_BITS bits were clocked.
module spi_slave_frame #(
  parameter int FRAME_BITS = 392,
  parameter int CNT_W      = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_load,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam logic [0:0] STATE_IDLE   = 1'b0;
  localparam logic [0:0] STATE_ACTIVE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_BITS + 1);

  logic [0:0]            state;
  logic                  cs_meta, cs_sync, cs_last;
  logic                  sclk_meta, sclk_sync, sclk_last;
  logic                  mosi_meta, mosi_sync;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  first_rise;
  logic [FRAME_BITS-1:0] shadow;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] rx_shift;

  logic cs_fall, cs_rise, sclk_fall, sclk_rise;

  // the *_last flops hold the previous synchronised level for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_last   <= 1'b1;
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_last <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      cs_meta   <= cs;
      cs_sync   <= cs_meta;
      cs_last   <= cs_sync;
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_last <= sclk_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign cs_fall   =  cs_last & ~cs_sync;
  assign cs_rise   = ~cs_last &  cs_sync;
  assign sclk_fall =  sclk_last & ~sclk_sync;
  assign sclk_rise = ~sclk_last &  sclk_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STATE_IDLE;
      bit_cnt    <= '0;
      first_rise <= 1'b0;
      shadow     <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (tx_load) shadow <= tx_data;

      if (state == STATE_IDLE) begin
        if (cs_fall) begin
          state      <= STATE_ACTIVE;
          bit_cnt    <= '0;
          first_rise <= 1'b1;
          // a load landing on the start cycle must win over the stale shadow
          tx_shift   <= tx_load ? tx_data : shadow;
        end
      end else begin
        if (cs_rise) begin
          // cs release outranks any sclk edge seen in the same cycle
          state <= STATE_IDLE;
          if (bit_cnt == CNT_FRAME) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          if (sclk_fall) begin
            rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_sync};
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (sclk_rise) begin
            if (first_rise) first_rise <= 1'b0;
            else            tx_shift   <= {tx_shift[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign busy = (state == STATE_ACTIVE);
  assign miso = busy & tx_shift[FRAME_BITS-1];

endmodule
